// File: rtl/pattern_sequencer_pkg.sv
// rtl/pattern_sequencer_pkg.sv - shared states, pattern indices and colour constants
package pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    SHOW       = 2'd1,
    SWITCH     = 2'd2
  } state_t;

  localparam logic [2:0] PAT_WHITE   = 3'd0;
  localparam logic [2:0] PAT_RED     = 3'd1;
  localparam logic [2:0] PAT_GREEN   = 3'd2;
  localparam logic [2:0] PAT_BLUE    = 3'd3;
  localparam logic [2:0] PAT_BARS    = 3'd4;
  localparam logic [2:0] PAT_CHECKER = 3'd5;
  localparam logic [2:0] PAT_RAMP    = 3'd6;

  localparam logic [11:0] COLOUR_WHITE   = 12'hFFF;
  localparam logic [11:0] COLOUR_YELLOW  = 12'hFF0;
  localparam logic [11:0] COLOUR_CYAN    = 12'h0FF;
  localparam logic [11:0] COLOUR_GREEN   = 12'h0F0;
  localparam logic [11:0] COLOUR_MAGENTA = 12'hF0F;
  localparam logic [11:0] COLOUR_RED     = 12'hF00;
  localparam logic [11:0] COLOUR_BLUE    = 12'h00F;
  localparam logic [11:0] COLOUR_BLACK   = 12'h000;

  localparam int BAR_WIDTH = 80;
  localparam int ACTIVE_W  = 640;
  localparam int ACTIVE_H  = 480;

  // Classic SMPTE-like order, left to right.
  function automatic logic [11:0] bar_colour(input logic [9:0] col);
    if      (col < 10'(BAR_WIDTH * 1)) return COLOUR_WHITE;
    else if (col < 10'(BAR_WIDTH * 2)) return COLOUR_YELLOW;
    else if (col < 10'(BAR_WIDTH * 3)) return COLOUR_CYAN;
    else if (col < 10'(BAR_WIDTH * 4)) return COLOUR_GREEN;
    else if (col < 10'(BAR_WIDTH * 5)) return COLOUR_MAGENTA;
    else if (col < 10'(BAR_WIDTH * 6)) return COLOUR_RED;
    else if (col < 10'(BAR_WIDTH * 7)) return COLOUR_BLUE;
    else                               return COLOUR_BLACK;
  endfunction

endpackage

// File: rtl/pattern_sequencer_button_debouncer.sv
// rtl/pattern_sequencer_button_debouncer.sv - button synchroniser, debounce counter, press pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock25MHz,
  input  logic resetN,
  input  logic buttonRaw,
  output logic pressPulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          stable;
  logic [CW-1:0] count;

  // A new level is accepted on its DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clock25MHz or negedge resetN) begin
    if (!resetN) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      stable     <= 1'b0;
      count      <= '0;
      pressPulse <= 1'b0;
    end else begin
      sync_q1    <= buttonRaw;
      sync_q2    <= sync_q1;
      pressPulse <= 1'b0;
      if (sync_q2 != stable) begin
        if (count == LAST_COUNT) begin
          stable     <= sync_q2;
          count      <= '0;
          pressPulse <= sync_q2;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - frame-aligned test-pattern selection and RGB rendering
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int NUM_PATTERNS       = 7,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int DEBOUNCE_CYCLES    = 250000
) (
  input  logic       clock25MHz,
  input  logic       resetN,
  input  logic       vsync,
  input  logic       canDisplayImage,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       buttonRaw,
  input  logic       autoMode,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [2:0] patternIndex,
  output logic       frameStrobe
);

  localparam logic [9:0] LAST_FRAME = 10'(FRAMES_PER_PATTERN - 1);
  localparam logic [2:0] LAST_INDEX = 3'(NUM_PATTERNS - 1);

  state_t      state;
  state_t      next_state;
  logic        vsync_q;
  logic        auto_q;
  logic        pending;
  logic        press_pulse;
  logic        frame_start;
  logic        expiry;
  logic        in_active;
  logic [9:0]  frame_cnt;
  logic [2:0]  next_index;
  logic [11:0] colour;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock25MHz(clock25MHz),
    .resetN    (resetN),
    .buttonRaw (buttonRaw),
    .pressPulse(press_pulse)
  );

  assign frame_start = vsync & ~vsync_q;
  // Expiry folds into the same frame start, so a press in the same frame gives one advance.
  assign expiry      = autoMode & auto_q & (state == SHOW) & frame_start & (frame_cnt == LAST_FRAME);
  assign next_index  = (patternIndex == LAST_INDEX) ? 3'd0 : patternIndex + 3'd1;
  assign in_active   = canDisplayImage & (x < 10'(ACTIVE_W)) & (y < 10'(ACTIVE_H));

  always_comb begin
    next_state = state;
    case (state)
      WAIT_FIRST: if (frame_start) next_state = SHOW;
      SHOW:       if (frame_start && (pending || expiry)) next_state = SWITCH;
      SWITCH:     next_state = SHOW;
      default:    next_state = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clock25MHz or negedge resetN) begin
    if (!resetN) begin
      state <= WAIT_FIRST;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock25MHz or negedge resetN) begin
    if (!resetN) begin
      vsync_q      <= 1'b0;
      frameStrobe  <= 1'b0;
      auto_q       <= 1'b0;
      pending      <= 1'b0;
      frame_cnt    <= '0;
      patternIndex <= PAT_WHITE;
    end else begin
      vsync_q     <= vsync;
      frameStrobe <= frame_start;
      auto_q      <= autoMode;

      if (state == SWITCH) begin
        pending <= press_pulse;
      end else if (press_pulse || expiry) begin
        pending <= 1'b1;
      end

      if (state == SWITCH || !autoMode || (autoMode != auto_q)) begin
        frame_cnt <= '0;
      end else if (state == SHOW && frame_start) begin
        frame_cnt <= (frame_cnt == LAST_FRAME) ? 10'd0 : frame_cnt + 10'd1;
      end

      if (state == SWITCH) begin
        patternIndex <= next_index;
      end
    end
  end

  always_comb begin
    colour = COLOUR_BLACK;
    case (patternIndex)
      PAT_WHITE:   colour = COLOUR_WHITE;
      PAT_RED:     colour = COLOUR_RED;
      PAT_GREEN:   colour = COLOUR_GREEN;
      PAT_BLUE:    colour = COLOUR_BLUE;
      PAT_BARS:    colour = bar_colour(x);
      PAT_CHECKER: colour = (x[5] ^ y[5]) ? COLOUR_WHITE : COLOUR_BLACK;
      PAT_RAMP:    colour = {x[9:6], x[9:6], x[9:6]};
      default:     colour = COLOUR_BLACK;
    endcase
  end

  always_ff @(posedge clock25MHz or negedge resetN) begin
    if (!resetN) begin
      {red, green, blue} <= COLOUR_BLACK;
    end else if (state == WAIT_FIRST || !in_active) begin
      {red, green, blue} <= COLOUR_BLACK;
    end else begin
      {red, green, blue} <= colour;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

  logic       clock25MHz = 1'b0;
  logic       resetN;
  logic       vsync;
  logic       canDisplayImage;
  logic [9:0] x;
  logic [9:0] y;
  logic       buttonRaw;
  logic       autoMode;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic [2:0] patternIndex;
  logic       frameStrobe;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_idx;

  always #20 clock25MHz = ~clock25MHz;

  pattern_sequencer #(
    .NUM_PATTERNS      (7),
    .FRAMES_PER_PATTERN(2),
    .DEBOUNCE_CYCLES   (4)
  ) dut (
    .clock25MHz     (clock25MHz),
    .resetN         (resetN),
    .vsync          (vsync),
    .canDisplayImage(canDisplayImage),
    .x              (x),
    .y              (y),
    .buttonRaw      (buttonRaw),
    .autoMode       (autoMode),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .patternIndex   (patternIndex),
    .frameStrobe    (frameStrobe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {20'd0, red, green, blue};
  endfunction

  task automatic tick();
    @(posedge clock25MHz);
    #1;
  endtask

  task automatic pixel(input logic [9:0] px, input logic [9:0] py, input logic de);
    x = px;
    y = py;
    canDisplayImage = de;
    tick();
  endtask

  task automatic press();
    buttonRaw = 1'b1;
    repeat (8) tick();
    buttonRaw = 1'b0;
    repeat (8) tick();
  endtask

  // Short synthetic frame: vsync high 3 cycles, then an active stretch.
  task automatic run_frame();
    int         strobes;
    logic [2:0] prev_idx;
    logic       prev_strobe;
    strobes = 0;
    vsync = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 3) vsync = 1'b0;
      if (i >= 8 && i < 20) begin
        canDisplayImage = 1'b1;
        x = 10'((i - 8) * 50);
        y = 10'(i);
      end else begin
        canDisplayImage = 1'b0;
      end
      prev_idx    = patternIndex;
      prev_strobe = frameStrobe;
      tick();
      if (frameStrobe === 1'b1) strobes++;
      if (patternIndex !== prev_idx) check("idx_change_after_strobe", 32'(prev_strobe), 32'd1);
    end
    check("one_strobe_per_frame", 32'(strobes), 32'd1);
  endtask

  initial begin
    resetN = 1'b0;
    vsync = 1'b0;
    canDisplayImage = 1'b0;
    x = '0;
    y = '0;
    buttonRaw = 1'b0;
    autoMode = 1'b0;
    repeat (2) tick();
    check("reset_rgb", rgb(), 32'h000);
    check("reset_idx", 32'(patternIndex), 32'd0);
    check("reset_strobe", 32'(frameStrobe), 32'd0);

    resetN = 1'b1;
    tick();
    pixel(10'd5, 10'd5, 1'b1);
    pixel(10'd6, 10'd5, 1'b1);
    check("rgb_before_first_frame", rgb(), 32'h000);

    run_frame();
    pixel(10'd5, 10'd5, 1'b1);
    check("pat0_white", rgb(), 32'hFFF);
    check("idx_after_first_frame", 32'(patternIndex), 32'd0);

    press();
    run_frame();
    check("manual_press1", 32'(patternIndex), 32'd1);
    pixel(10'd5, 10'd5, 1'b1);
    check("pat1_red", rgb(), 32'hF00);

    press();
    run_frame();
    check("manual_press2", 32'(patternIndex), 32'd2);
    pixel(10'd5, 10'd5, 1'b1);
    check("pat2_green", rgb(), 32'h0F0);

    press();
    run_frame();
    check("manual_press3", 32'(patternIndex), 32'd3);
    pixel(10'd5, 10'd5, 1'b1);
    check("pat3_blue", rgb(), 32'h00F);

    repeat (3) begin
      buttonRaw = 1'b1;
      repeat (3) tick();
      buttonRaw = 1'b0;
      repeat (3) tick();
    end
    repeat (4) tick();
    run_frame();
    check("glitch_no_step", 32'(patternIndex), 32'd3);

    buttonRaw = 1'b1;
    repeat (5) run_frame();
    buttonRaw = 1'b0;
    repeat (8) tick();
    run_frame();
    check("held_single_step", 32'(patternIndex), 32'd4);

    pixel(10'd79, 10'd100, 1'b1);
    check("bars_x79", rgb(), 32'hFFF);
    x = 10'd80;
    #1;
    check("bars_latency_hold", rgb(), 32'hFFF);
    tick();
    check("bars_x80", rgb(), 32'hFF0);
    pixel(10'd300, 10'd100, 1'b1);
    check("bars_x300", rgb(), 32'h0F0);
    pixel(10'd639, 10'd100, 1'b1);
    check("bars_x639", rgb(), 32'h000);
    pixel(10'd79, 10'd100, 1'b0);
    check("blank_when_not_active", rgb(), 32'h000);

    press();
    run_frame();
    check("manual_idx5", 32'(patternIndex), 32'd5);
    pixel(10'd32, 10'd0, 1'b1);
    check("checker_x32_y0", rgb(), 32'hFFF);
    pixel(10'd32, 10'd32, 1'b1);
    check("checker_x32_y32", rgb(), 32'h000);

    press();
    run_frame();
    check("manual_idx6", 32'(patternIndex), 32'd6);
    pixel(10'd200, 10'd0, 1'b1);
    check("ramp_x200", rgb(), 32'h333);
    pixel(10'd639, 10'd479, 1'b1);
    check("ramp_x639", rgb(), 32'h999);

    press();
    run_frame();
    check("manual_wrap", 32'(patternIndex), 32'd0);

    autoMode = 1'b1;
    repeat (2) tick();
    exp_idx = 0;
    for (int k = 1; k <= 14; k++) begin
      run_frame();
      if (k % 2 == 0) exp_idx = (exp_idx + 1) % 7;
      check("auto_step", 32'(patternIndex), 32'(exp_idx));
    end

    run_frame();
    check("auto_before_press", 32'(patternIndex), 32'd0);
    press();
    run_frame();
    check("press_with_expiry", 32'(patternIndex), 32'd1);
    run_frame();
    check("no_double_step", 32'(patternIndex), 32'd1);
    run_frame();
    check("auto_resumes", 32'(patternIndex), 32'd2);

    pixel(10'd5, 10'd5, 1'b1);
    check("pre_reset_rgb", rgb(), 32'h0F0);
    resetN = 1'b0;
    #1;
    check("midframe_reset_rgb", rgb(), 32'h000);
    check("midframe_reset_idx", 32'(patternIndex), 32'd0);
    tick();
    check("midframe_reset_strobe", 32'(frameStrobe), 32'd0);
    resetN = 1'b1;
    tick();
    pixel(10'd5, 10'd5, 1'b1);
    check("rgb_wait_after_reset", rgb(), 32'h000);
    run_frame();
    pixel(10'd5, 10'd5, 1'b1);
    check("rgb_after_reset_frame", rgb(), 32'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
